// File: rtl/idli_sqi_mem_if.sv
// SQI responder bus: serial link from the core plus backdoor preload port.
interface idli_sqi_mem_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              i_sqimem_sck;
  logic              i_sqimem_cs;
  logic [3:0]        i_sqimem_sio;
  logic [3:0]        o_sqimem_sio;
  logic              o_sqimem_sio_oe;
  logic              i_sqimem_bd_we;
  logic [ADDR_W-1:0] i_sqimem_bd_addr;
  logic [7:0]        i_sqimem_bd_data;
  logic              o_sqimem_err;

  // Memory side.
  modport slave (
    input  i_sqimem_sck, i_sqimem_cs, i_sqimem_sio,
    input  i_sqimem_bd_we, i_sqimem_bd_addr, i_sqimem_bd_data,
    output o_sqimem_sio, o_sqimem_sio_oe, o_sqimem_err
  );

  // Core / harness side.
  modport master (
    output i_sqimem_sck, i_sqimem_cs, i_sqimem_sio,
    output i_sqimem_bd_we, i_sqimem_bd_addr, i_sqimem_bd_data,
    input  o_sqimem_sio, o_sqimem_sio_oe, o_sqimem_err
  );
endinterface

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder backed by a local byte array.
// Supports sequential READ (0x03) and WRITE (0x02) in quad mode only.
module idli_sqi_mem_m #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DUMMY_CYC = 2
) (
  input logic            i_sqimem_gck,
  input logic            i_sqimem_rst,
  idli_sqi_mem_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StIgnore
  } state_t;

  state_t            state_q;
  logic              sck_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic [3:0]        hold_q;
  logic              phase_q;
  logic [7:0]        sr_q;
  logic [3:0]        sio_q;
  logic              oe_q;
  logic              err_q;

  logic [7:0]        mem [2**ADDR_W];

  logic              rise;
  logic              fall;
  logic [ADDR_W-1:0] addr_shift;
  logic [7:0]        cmd;
  logic              wr_en;

  // Edge detect in the gck domain and next-address/command assembly.
  always_comb begin
    rise       = bus.i_sqimem_sck & ~sck_q;
    fall       = ~bus.i_sqimem_sck & sck_q;
    // Shifting through an ADDR_W-wide register keeps only the low bits of the 24-bit address.
    addr_shift = ADDR_W'({addr_q, bus.i_sqimem_sio});
    cmd        = {hold_q, bus.i_sqimem_sio};
    wr_en      = ~i_sqimem_rst & ~bus.i_sqimem_cs & (state_q == StWdata) & rise & phase_q;
  end

  // Array port: protocol write while selected, backdoor preload only while deselected.
  always_ff @(posedge i_sqimem_gck) begin
    if (wr_en) begin
      mem[addr_q] <= {hold_q, bus.i_sqimem_sio};
    end else if (bus.i_sqimem_bd_we && bus.i_sqimem_cs) begin
      mem[bus.i_sqimem_bd_addr] <= bus.i_sqimem_bd_data;
    end
  end

  // Protocol FSM with registered sio/oe/err outputs.
  always_ff @(posedge i_sqimem_gck) begin
    sck_q <= bus.i_sqimem_sck;
    if (i_sqimem_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      hold_q  <= '0;
      phase_q <= 1'b0;
      sr_q    <= '0;
      sio_q   <= '0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.i_sqimem_cs) begin
      // Deselect aborts anything in flight, including a half-written byte.
      state_q <= StIdle;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StCmd;
          cnt_q   <= '0;
          phase_q <= 1'b0;
        end
        StCmd: begin
          if (rise) begin
            if (cnt_q == 8'd0) begin
              hold_q <= bus.i_sqimem_sio;
              cnt_q  <= 8'd1;
            end else begin
              cnt_q <= '0;
              if (cmd == 8'h03) begin
                rd_q    <= 1'b1;
                state_q <= StAddr;
              end else if (cmd == 8'h02) begin
                rd_q    <= 1'b0;
                state_q <= StAddr;
              end else begin
                err_q   <= 1'b1;
                state_q <= StIgnore;
              end
            end
          end
        end
        StAddr: begin
          if (rise) begin
            addr_q <= addr_shift;
            if (cnt_q == 8'd5) begin
              cnt_q <= '0;
              if (!rd_q) begin
                state_q <= StWdata;
              end else if (DUMMY_CYC == 0) begin
                sr_q    <= mem[addr_shift];
                state_q <= StRdata;
              end else begin
                state_q <= StDummy;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StDummy: begin
          if (rise) begin
            if (cnt_q == 8'(DUMMY_CYC - 1)) begin
              cnt_q   <= '0;
              sr_q    <= mem[addr_q];
              state_q <= StRdata;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StRdata: begin
          if (fall) begin
            oe_q <= 1'b1;
            if (!phase_q) begin
              sio_q   <= sr_q[7:4];
              phase_q <= 1'b1;
            end else begin
              sio_q   <= sr_q[3:0];
              addr_q  <= addr_q + 1'b1;
              phase_q <= 1'b0;
            end
          end else if (!phase_q) begin
            // Refetch between bytes so the next high nibble sees the incremented address.
            sr_q <= mem[addr_q];
          end
        end
        StWdata: begin
          if (rise) begin
            if (!phase_q) begin
              hold_q  <= bus.i_sqimem_sio;
              phase_q <= 1'b1;
            end else begin
              addr_q  <= addr_q + 1'b1;
              phase_q <= 1'b0;
            end
          end
        end
        StIgnore: begin
          state_q <= StIgnore;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_sqimem_sio    = sio_q;
  assign bus.o_sqimem_sio_oe = oe_q;
  assign bus.o_sqimem_err    = err_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed and randomized bench for the SQI memory responder.
module tb_idli_sqi_mem_m;

  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned DUMMY_CYC = 2;
  localparam int          DEPTH     = 1 << ADDR_W;

  logic gck = 1'b0;
  logic rst;

  idli_sqi_mem_if #(.ADDR_W(ADDR_W)) bus ();

  idli_sqi_mem_m #(
    .ADDR_W    (ADDR_W),
    .DUMMY_CYC (DUMMY_CYC)
  ) dut (
    .i_sqimem_gck (gck),
    .i_sqimem_rst (rst),
    .bus          (bus)
  );

  always #5 gck = ~gck;

  int total = 0;
  int bad   = 0;

  // Reference array: what the memory must hold after each bench operation.
  logic [7:0] model [int];
  logic       err_exp;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge gck);
  endtask

  // One sck period; returns what the responder presents just before the rising edge.
  task automatic sck_cycle(input logic [3:0] nin, output logic [3:0] nout, output logic oe);
    bus.i_sqimem_sio = nin;
    tick(2);
    nout = bus.o_sqimem_sio;
    oe   = bus.o_sqimem_sio_oe;
    bus.i_sqimem_sck = 1'b1;
    tick(4);
    bus.i_sqimem_sck = 1'b0;
    tick(4);
  endtask

  task automatic send_nibbles(input logic [31:0] val, input int n);
    logic [3:0] dn;
    logic       doe;
    for (int i = n - 1; i >= 0; i--) sck_cycle(val[4*i +: 4], dn, doe);
  endtask

  task automatic cs_low();
    bus.i_sqimem_cs = 1'b0;
    tick(2);
  endtask

  task automatic cs_high();
    bus.i_sqimem_cs = 1'b1;
    tick(3);
  endtask

  task automatic start(input logic [7:0] cmd, input int addr);
    cs_low();
    send_nibbles(32'(cmd), 2);
    send_nibbles(32'(addr), 6);
  endtask

  task automatic bd_write(input int a, input logic [7:0] d);
    bus.i_sqimem_bd_we   = 1'b1;
    bus.i_sqimem_bd_addr = ADDR_W'(a);
    bus.i_sqimem_bd_data = d;
    tick(1);
    bus.i_sqimem_bd_we = 1'b0;
    model[a % DEPTH] = d;
  endtask

  task automatic do_write(input int addr, input logic [7:0] data [$]);
    start(8'h02, addr);
    foreach (data[i]) begin
      send_nibbles(32'(data[i]), 2);
      model[(addr + i) % DEPTH] = data[i];
    end
    cs_high();
  endtask

  // Leaves cs low so the caller can observe oe before deselect.
  task automatic do_read(input int addr, input int len, output logic [7:0] got [$],
                         output logic oe_all);
    logic [3:0] hi, lo;
    logic       oe1, oe2;
    got    = {};
    oe_all = 1'b1;
    start(8'h03, addr);
    repeat (DUMMY_CYC) send_nibbles(32'($urandom_range(0, 15)), 1);
    for (int i = 0; i < len; i++) begin
      sck_cycle(4'($urandom_range(0, 15)), hi, oe1);
      sck_cycle(4'($urandom_range(0, 15)), lo, oe2);
      got.push_back({hi, lo});
      oe_all = oe_all & oe1 & oe2;
    end
  endtask

  task automatic check_read(input string tag, input int addr, input int len);
    logic [7:0] got [$];
    logic       oe_all;
    do_read(addr, len, got, oe_all);
    for (int i = 0; i < len; i++) check(tag, got[i], model[(addr + i) % DEPTH]);
    check({tag, "_oe_hi"}, 8'(oe_all), 8'd1);
    check({tag, "_err"}, 8'(bus.o_sqimem_err), 8'(err_exp));
    cs_high();
    check({tag, "_oe_lo"}, 8'(bus.o_sqimem_sio_oe), 8'd0);
  endtask

  // Hard bound on total run time.
  initial begin
    #3ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] data [$];
    logic [3:0] dn;
    logic       doe;
    int         a;
    int         len;

    rst                  = 1'b1;
    bus.i_sqimem_sck     = 1'b0;
    bus.i_sqimem_cs      = 1'b1;
    bus.i_sqimem_sio     = 4'h0;
    bus.i_sqimem_bd_we   = 1'b0;
    bus.i_sqimem_bd_addr = '0;
    bus.i_sqimem_bd_data = '0;
    err_exp              = 1'b0;
    tick(3);
    rst = 1'b0;

    // Idle sck with cs high: nothing driven, no error.
    repeat (5) send_nibbles(32'($urandom_range(0, 15)), 1);
    check("rst_oe", 8'(bus.o_sqimem_sio_oe), 8'd0);
    check("rst_sio", 8'(bus.o_sqimem_sio), 8'd0);
    check("rst_err", 8'(bus.o_sqimem_err), 8'd0);

    // Basic read of a preloaded pair.
    bd_write(32'h10, 8'hA5);
    bd_write(32'h11, 8'h3C);
    check_read("rd_basic", 32'h10, 2);

    // Write across the top of the array and read back through the wrap.
    data = '{8'h12, 8'h34};
    do_write(32'h1FFFF, data);
    check_read("wr_wrap", 32'h1FFFF, 2);
    check_read("wr_wrap_lo", 32'h0, 1);

    // Trailing half byte must be dropped on deselect.
    bd_write(32'h21, 8'($urandom_range(0, 255)));
    start(8'h02, 32'h20);
    send_nibbles(32'h77, 2);
    send_nibbles(32'h9, 1);
    cs_high();
    model[32'h20] = 8'h77;
    check_read("wr_half", 32'h20, 2);

    // Unsupported command: sticky error, sio never driven.
    start(8'h05, 0);
    err_exp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sck_cycle(4'($urandom_range(0, 15)), dn, doe);
      check("bad_cmd_oe", 8'(doe), 8'd0);
    end
    cs_high();
    check("bad_cmd_err", 8'(bus.o_sqimem_err), 8'd1);
    check_read("after_bad", 32'h10, 2);

    // Abort mid-address, then reset during a read data phase.
    cs_low();
    send_nibbles(32'h03, 2);
    send_nibbles(32'h000, 3);
    cs_high();
    start(8'h03, 32'h10);
    repeat (DUMMY_CYC) send_nibbles(32'h0, 1);
    sck_cycle(4'h0, dn, doe);
    check("pre_rst_nib", 8'(dn), 8'hA);
    rst = 1'b1;
    tick(1);
    err_exp = 1'b0;
    check("rst_mid_oe", 8'(bus.o_sqimem_sio_oe), 8'd0);
    check("rst_mid_err", 8'(bus.o_sqimem_err), 8'd0);
    rst = 1'b0;
    cs_high();
    check_read("after_rst", 32'h1FFFF, 2);

    // Random write/readback traffic plus random backdoor preloads.
    for (int t = 0; t < 8; t++) begin
      a   = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(1, 4));
      data = {};
      for (int i = 0; i < len; i++) data.push_back(8'($urandom_range(0, 255)));
      do_write(a, data);
      check_read("rnd_wr", a, len);
      a = int'($urandom_range(0, DEPTH - 1));
      bd_write(a, 8'($urandom_range(0, 255)));
      check_read("rnd_bd", a, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
